// File: rtl/cnn_layer_accel_result_packer.sv
// Result packer: gathers 16-bit quad results into 128-bit lane words and queues them for write-back.
// Latency: a completed word is visible on pack_valid one clk_core edge after its final lane is accepted.
// Backpressure: result_accept drops while the word FIFO is full; pack outputs hold while !pack_ready.
// Optional build: define CNN_LAYER_ACCEL_RESULT_PACKER_RELU_EN to clamp negative results to zero before packing.
module cnn_layer_accel_result_packer #(
  parameter int C_NUM_LANES  = 8,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                       clk_core,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [C_CNT_WIDTH-1:0]     num_results,
  output logic                       busy,
  output logic                       job_done,
  input  logic                       result_valid,
  output logic                       result_accept,
  input  logic [15:0]                result_data,
  output logic                       pack_valid,
  input  logic                       pack_ready,
  output logic [C_NUM_LANES*16-1:0]  pack_data,
  output logic [C_NUM_LANES-1:0]     pack_keep,
  output logic                       pack_last
);

  localparam int W  = C_NUM_LANES * 16;
  localparam int LW = $clog2(C_NUM_LANES);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int EW = W + C_NUM_LANES + 1;
  localparam logic [AW:0]          FULL_CNT  = (AW+1)'(C_FIFO_DEPTH);
  localparam logic [AW:0]          CNT_ONE   = (AW+1)'(1);
  localparam logic [LW-1:0]        LANE_MAX  = LW'(C_NUM_LANES - 1);
  localparam logic [LW-1:0]        LANE_ONE  = LW'(1);
  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
  localparam logic [C_CNT_WIDTH-1:0] REM_ONE = C_CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    job_done_nxt;
  logic [LW-1:0]           lane;
  logic [W-1:0]            asm_word;
  logic [C_CNT_WIDTH-1:0]  remaining;

  logic [EW-1:0]           mem [C_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    rx;
  logic                    final_res;
  logic                    push;
  logic                    pop;
  logic [15:0]             res_val;
  logic [W-1:0]            word;
  logic [C_NUM_LANES-1:0]  keep;

  // Full is judged from the registered count only, so a full FIFO never takes a word even if it pops this cycle.
  assign fifo_full     = (count == FULL_CNT);
  assign fifo_empty    = (count == '0);
  assign result_accept = (state == S_PACK) && !fifo_full;
  assign rx            = result_valid && result_accept;
  assign final_res     = (remaining == REM_ONE);
  assign push          = rx && ((lane == LANE_MAX) || final_res);
  assign pop           = pack_valid && pack_ready;
  assign busy          = (state != S_IDLE);

`ifdef CNN_LAYER_ACCEL_RESULT_PACKER_RELU_EN
  assign res_val = result_data[15] ? 16'h0000 : result_data;
`else
  assign res_val = result_data;
`endif

  // Merge the incoming result into the partial word; lanes above the current one are still zero.
  always_comb begin
    word = asm_word;
    word[lane*16 +: 16] = res_val;
    keep = {C_NUM_LANES{1'b1}} >> (LANE_MAX - lane);
  end

  // Next-state and job_done decode.
  always_comb begin
    state_nxt    = state;
    job_done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_start) begin
          if (num_results == '0) job_done_nxt = 1'b1;
          else                   state_nxt    = S_PACK;
        end
      end
      S_PACK: begin
        if (rx && final_res) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The last word is the last entry in the FIFO, so its pop is the job's final transfer.
        if (fifo_empty || (pop && count == CNT_ONE)) begin
          job_done_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered completion pulse.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      job_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      job_done <= job_done_nxt;
    end
  end

  // Lane assembly and remaining-result counter.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      lane      <= '0;
      asm_word  <= '0;
      remaining <= '0;
    end else if (state == S_IDLE) begin
      if (job_start && num_results != '0) begin
        remaining <= num_results;
        lane      <= '0;
        asm_word  <= '0;
      end
    end else if (rx) begin
      remaining <= remaining - REM_ONE;
      if (push) begin
        lane     <= '0;
        asm_word <= '0;
      end else begin
        lane     <= lane + LANE_ONE;
        asm_word <= word;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {last, keep, data} per entry.
  always_ff @(posedge clk_core) begin
    if (push) mem[wr_ptr] <= {final_res, keep, word};
  end

  // Head entry drives the output; gated to zero while empty so idle/reset outputs read as zero.
  always_comb begin
    pack_valid = !fifo_empty;
    {pack_last, pack_keep, pack_data} = pack_valid ? mem[rd_ptr] : '0;
  end

endmodule
